// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory access unit and the data memory.
//   master : the access unit (drives the request, address, data, byte enables)
//   slave  : the memory (returns mem_ack with mem_rdata)
interface memory_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory access pipeline stage. Memory instructions (bits [27:26]=01) issue a
// single word or byte access on the data bus and stall upstream until the
// memory acknowledges or the timeout aborts the access. Other instructions and
// squashed slots (epoch mismatch) pass through with one cycle of latency.
// Ports:
//   clk, rst_n      : clock, asynchronous reset (active high despite the name)
//   instr_in, branch_ref, branch_in, addr_in, wdata_in : upstream slot
//   stall_in        : hold request from the downstream stage
//   mem             : data-memory bus (master side)
//   instr_output, branch_value, load_data : registered results downstream
//   stall_out       : hold request to upstream
//   mem_error       : one-cycle pulse when an access times out
module memory_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'hE1A00000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 instr_in,
  input  logic                        branch_ref,
  input  logic                        branch_in,
  input  logic [31:0]                 addr_in,
  input  logic [31:0]                 wdata_in,
  input  logic                        stall_in,
  memory_access_unit_if.master        mem,
  output logic [31:0]                 instr_output,
  output logic                        branch_value,
  output logic [31:0]                 load_data,
  output logic                        stall_out,
  output logic                        mem_error
);

  // The counter holds 0..TIMEOUT_CYCLES-1; reaching the last value without an
  // ack is what triggers the abort.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ABORT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          byte_q, byte_d;
  logic [31:0]   slot_instr_q, slot_instr_d;
  logic          slot_br_q, slot_br_d;
  logic [31:0]   instr_output_q, instr_output_d;
  logic          branch_value_q, branch_value_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          mem_error_q, mem_error_d;

  logic          is_mem_s;
  logic          squash_s;

  // Zero-extended byte lane of a loaded word.
  function automatic logic [31:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] r;
    case (lane)
      2'd0:    r = {24'h000000, word[7:0]};
      2'd1:    r = {24'h000000, word[15:8]};
      2'd2:    r = {24'h000000, word[23:16]};
      2'd3:    r = {24'h000000, word[31:24]};
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  assign is_mem_s  = (instr_in[27:26] == 2'b01);
  assign squash_s  = (branch_in != branch_ref);
  assign stall_out = (state_q != S_IDLE) || stall_in;

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    byte_d         = byte_q;
    slot_instr_d   = slot_instr_q;
    slot_br_d      = slot_br_q;
    instr_output_d = instr_output_q;
    branch_value_d = branch_value_q;
    load_data_d    = load_data_q;
    mem_error_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stall_in) begin
          state_d = S_IDLE;
        end else if (is_mem_s && !squash_s) begin
          state_d      = S_ACCESS;
          count_d      = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = ~instr_in[20];
          byte_d       = instr_in[22];
          slot_instr_d = instr_in;
          slot_br_d    = branch_in;
          if (instr_in[22]) begin
            mem_addr_d  = addr_in;
            mem_be_d    = 4'b0001 << addr_in[1:0];
            mem_wdata_d = {4{wdata_in[7:0]}};
          end else begin
            mem_addr_d  = {addr_in[31:2], 2'b00};
            mem_be_d    = 4'b1111;
            mem_wdata_d = wdata_in;
          end
        end else begin
          instr_output_d = squash_s ? NOP_INSTR : instr_in;
          branch_value_d = branch_in;
        end
      end

      S_ACCESS: begin
        // An ack on the last allowed cycle still completes normally.
        if (mem.mem_ack) begin
          state_d        = S_IDLE;
          mem_req_d      = 1'b0;
          instr_output_d = slot_instr_q;
          branch_value_d = slot_br_q;
          if (!mem_we_q) begin
            load_data_d = byte_q ? pick_byte(mem.mem_rdata, mem_addr_q[1:0]) : mem.mem_rdata;
          end else begin
            load_data_d = load_data_q;
          end
        end else if (count_q == LIMIT_M1) begin
          state_d        = S_ABORT;
          mem_req_d      = 1'b0;
          mem_error_d    = 1'b1;
          instr_output_d = NOP_INSTR;
          branch_value_d = slot_br_q;
        end else begin
          count_d = count_q + CW'(1'b1);
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request at once.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'h00000000;
      mem_wdata_q    <= 32'h00000000;
      mem_be_q       <= 4'b0000;
      byte_q         <= 1'b0;
      slot_instr_q   <= NOP_INSTR;
      slot_br_q      <= 1'b0;
      instr_output_q <= NOP_INSTR;
      branch_value_q <= 1'b0;
      load_data_q    <= 32'h00000000;
      mem_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      byte_q         <= byte_d;
      slot_instr_q   <= slot_instr_d;
      slot_br_q      <= slot_br_d;
      instr_output_q <= instr_output_d;
      branch_value_q <= branch_value_d;
      load_data_q    <= load_data_d;
      mem_error_q    <= mem_error_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;
  assign instr_output  = instr_output_q;
  assign branch_value  = branch_value_q;
  assign load_data     = load_data_q;
  assign mem_error     = mem_error_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit (TIMEOUT_CYCLES=4): directed vector table,
// hand-written multi-cycle sequences, and randomized slots checked against a
// transaction-level reference model.
module tb_memory_access_unit;
  localparam int TO = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;
  localparam logic [31:0] LDR  = 32'hE5900000;
  localparam logic [31:0] LDRB = 32'hE5D00000;
  localparam logic [31:0] STR  = 32'hE5800000;
  localparam logic [31:0] STRB = 32'hE5C00000;
  localparam logic [31:0] ADD  = 32'hE0801002;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        branch_ref;
  logic        branch_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall_in;
  logic [31:0] instr_output;
  logic        branch_value;
  logic [31:0] load_data;
  logic        stall_out;
  logic        mem_error;

  memory_access_unit_if mif();

  memory_access_unit #(.TIMEOUT_CYCLES(TO), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .branch_ref(branch_ref),
    .branch_in(branch_in), .addr_in(addr_in), .wdata_in(wdata_in), .stall_in(stall_in),
    .mem(mif), .instr_output(instr_output), .branch_value(branch_value),
    .load_data(load_data), .stall_out(stall_out), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        br_ref;
    logic        br;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;        // ACCESS cycle in which ack arrives (0 = never)
    logic        acc;      // an access is expected
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_out;
    logic        e_ld_upd;
    logic [31:0] e_load;
    int          e_stall;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_load = 32'h0;
  logic [31:0] last_out  = NOP;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_req", {31'h0, mif.mem_req}, 32'h0);
    chk("rst_we", {31'h0, mif.mem_we}, 32'h0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);
    chk("rst_be", {28'h0, mif.mem_be}, 32'h0);
    chk("rst_out", instr_output, NOP);
    chk("rst_br", {31'h0, branch_value}, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_err", {31'h0, mem_error}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
  endtask

  // Reference model: what one upstream slot should produce, from the rules.
  function automatic vec_t model(input logic [31:0] instr, input logic br_ref, input logic br,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int d);
    vec_t v;
    bit is_mem, squash, is_byte, is_load, timeout;
    is_mem  = (((instr >> 26) % 4) == 1);
    squash  = (br != br_ref);
    is_byte = instr[22];
    is_load = instr[20];
    timeout = (d == 0) || (d > TO);
    v.instr = instr; v.br_ref = br_ref; v.br = br; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.d = d;
    v.acc      = is_mem && !squash;
    v.e_addr   = is_byte ? addr : (addr / 4) * 4;
    v.e_be     = is_byte ? 4'(1 << (addr % 4)) : 4'hF;
    v.e_wdata  = is_byte ? (wdata % 256) * 32'h01010101 : wdata;
    v.e_we     = !is_load;
    v.e_ld_upd = v.acc && is_load && !timeout;
    v.e_load   = is_byte ? (rdata >> (8 * (addr % 4))) % 256 : rdata;
    if (squash)       v.e_out = NOP;
    else if (!v.acc)  v.e_out = instr;
    else if (timeout) v.e_out = NOP;
    else              v.e_out = instr;
    v.e_stall  = !v.acc ? 0 : (timeout ? TO + 1 : d);
    return v;
  endfunction

  // Present one slot from IDLE, play the memory side, and check the results.
  task automatic run_slot(input vec_t v);
    int  k;
    int  stalls;
    bit  done;
    instr_in = v.instr; branch_ref = v.br_ref; branch_in = v.br;
    addr_in = v.addr; wdata_in = v.wdata; stall_in = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    @(posedge clk); #1;
    stalls = 0;
    if (v.acc) begin
      chk("acc_req", {31'h0, mif.mem_req}, 32'h1);
      chk("acc_addr", mif.mem_addr, v.e_addr);
      chk("acc_be", {28'h0, mif.mem_be}, {28'h0, v.e_be});
      chk("acc_wdata", mif.mem_wdata, v.e_wdata);
      chk("acc_we", {31'h0, mif.mem_we}, {31'h0, v.e_we});
      k = 1; done = 0;
      while (!done) begin
        if (stall_out) stalls++;
        if (k == v.d) begin
          mif.mem_ack = 1'b1; mif.mem_rdata = v.rdata;
          @(posedge clk); #1;
          mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
          chk("ack_no_err", {31'h0, mem_error}, 32'h0);
          done = 1;
        end else if (k >= TO) begin
          @(posedge clk); #1;
          if (stall_out) stalls++;
          chk("abort_err", {31'h0, mem_error}, 32'h1);
          chk("abort_req", {31'h0, mif.mem_req}, 32'h0);
          chk("abort_out", instr_output, NOP);
          @(posedge clk); #1;
          chk("err_pulse", {31'h0, mem_error}, 32'h0);
          done = 1;
        end else begin
          chk("hold_req", {31'h0, mif.mem_req}, 32'h1);
          chk("hold_addr", mif.mem_addr, v.e_addr);
          @(posedge clk); #1;
          k++;
        end
      end
      chk("stall_cycles", stalls, v.e_stall);
    end else begin
      chk("pass_req", {31'h0, mif.mem_req}, 32'h0);
    end
    if (v.e_ld_upd) last_load = v.e_load;
    last_out = v.e_out;
    chk("instr_out", instr_output, v.e_out);
    chk("branch_val", {31'h0, branch_value}, {31'h0, v.br});
    chk("load_data", load_data, last_load);
    chk("idle_req", {31'h0, mif.mem_req}, 32'h0);
    chk("idle_stall", {31'h0, stall_out}, 32'h0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b1; instr_in = ADD; branch_ref = 1'b0; branch_in = 1'b0;
    addr_in = 32'h0; wdata_in = 32'h0; stall_in = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    stall_in = 1'b1; #1;
    chk("rst_stall_in", {31'h0, stall_out}, 32'h1);
    stall_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Directed vectors
    //          instr ref br addr          wdata         rdata         d  acc e_addr        be       e_wdata       we   e_out ld  e_load        stall
    tbl[0] = '{LDR,  1'b0, 1'b0, 32'h1003, 32'h12345678, 32'hDEADBEEF, 3, 1'b1, 32'h1000, 4'b1111, 32'h12345678, 1'b0, LDR,  1'b1, 32'hDEADBEEF, 3};
    tbl[1] = '{STRB, 1'b0, 1'b0, 32'h2002, 32'h000000A5, 32'h0,        1, 1'b1, 32'h2002, 4'b0100, 32'hA5A5A5A5, 1'b1, STRB, 1'b0, 32'h0,        1};
    tbl[2] = '{LDRB, 1'b0, 1'b0, 32'h0011, 32'h0,        32'h11223344, 2, 1'b1, 32'h0011, 4'b0010, 32'h0,        1'b0, LDRB, 1'b1, 32'h00000033, 2};
    tbl[3] = '{LDR,  1'b0, 1'b1, 32'h0100, 32'h0,        32'h0,        1, 1'b0, 32'h0,    4'b0000, 32'h0,        1'b0, NOP,  1'b0, 32'h0,        0};
    tbl[4] = '{ADD,  1'b1, 1'b1, 32'h0200, 32'h0,        32'h0,        1, 1'b0, 32'h0,    4'b0000, 32'h0,        1'b0, ADD,  1'b0, 32'h0,        0};
    tbl[5] = '{STR,  1'b1, 1'b1, 32'h3006, 32'hCAFEF00D, 32'h0,        4, 1'b1, 32'h3004, 4'b1111, 32'hCAFEF00D, 1'b1, STR,  1'b0, 32'h0,        4};
    tbl[6] = '{LDRB, 1'b0, 1'b0, 32'h0503, 32'h0,        32'h9A000000, 1, 1'b1, 32'h0503, 4'b1000, 32'h0,        1'b0, LDRB, 1'b1, 32'h0000009A, 1};
    tbl[7] = '{LDR,  1'b0, 1'b0, 32'h0042, 32'h0,        32'h55555555, 0, 1'b1, 32'h0040, 4'b1111, 32'h0,        1'b0, NOP,  1'b0, 32'h0,        5};
    for (int i = 0; i < 8; i++) run_slot(tbl[i]);

    // Late ack after the abort is ignored
    instr_in = ADD; branch_ref = 1'b0; branch_in = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    chk("late_load", load_data, last_load);
    chk("late_err", {31'h0, mem_error}, 32'h0);
    chk("late_req", {31'h0, mif.mem_req}, 32'h0);
    chk("late_out", instr_output, ADD);
    last_out = ADD;

    // stall_in in IDLE: nothing starts, outputs hold
    instr_in = LDR; addr_in = 32'h0800; stall_in = 1'b1; #1;
    chk("istall_stall_out", {31'h0, stall_out}, 32'h1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("istall_req", {31'h0, mif.mem_req}, 32'h0);
      chk("istall_out", instr_output, last_out);
    end
    run_slot(model(LDR, 1'b0, 1'b0, 32'h0800, 32'h0, 32'h76543210, 1));

    // stall_in during ACCESS: access completes, result held until stall drops
    instr_in = LDR; addr_in = 32'h0704; stall_in = 1'b0;
    @(posedge clk); #1;
    stall_in = 1'b1;
    @(posedge clk); #1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    chk("astall_out", instr_output, LDR);
    chk("astall_load", load_data, 32'h0BADF00D);
    chk("astall_req", {31'h0, mif.mem_req}, 32'h0);
    @(posedge clk); #1;
    chk("astall_hold_out", instr_output, LDR);
    chk("astall_hold_req", {31'h0, mif.mem_req}, 32'h0);
    chk("astall_stall", {31'h0, stall_out}, 32'h1);
    stall_in = 1'b0;
    last_load = 32'h0BADF00D; last_out = LDR;

    // Randomized slots against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      logic        ref_b;
      logic        br_b;
      case ($urandom_range(0, 4))
        0:       ins = LDR;
        1:       ins = LDRB;
        2:       ins = STR;
        3:       ins = STRB;
        default: ins = {4'hE, 2'($urandom_range(2, 4) % 4), 26'($urandom)};
      endcase
      ins[19:0] = 20'($urandom);
      ref_b = 1'($urandom);
      br_b  = ($urandom_range(0, 3) == 0) ? ~ref_b : ref_b;
      v = model(ins, ref_b, br_b, $urandom, $urandom, $urandom, $urandom_range(1, 6));
      run_slot(v);
    end

    // Reset asserted mid-ACCESS
    instr_in = LDR; branch_ref = 1'b0; branch_in = 1'b0; addr_in = 32'h0600;
    mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_pre_req", {31'h0, mif.mem_req}, 32'h1);
    #2;
    rst_n = 1'b1; #1;
    check_reset_values();
    instr_in = ADD;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_err", {31'h0, mem_error}, 32'h0);
      chk("post_rst_req", {31'h0, mif.mem_req}, 32'h0);
    end
    chk("post_rst_out", instr_output, ADD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of ACCESS cycles allowed without mem_ack before the access is aborted.
REQ-002 SHALL have parameter NOP_INSTR, default 32'hE1A00000, the instruction word emitted for squashed or aborted slots.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous reset, asserted at 1 (active-high).
REQ-005 instr_in  in  32  instruction from the upstream stage; held stable by upstream while stall_out=1.
REQ-006 branch_ref  in  1  current pipeline branch epoch.
REQ-007 branch_in  in  1  epoch tag of instr_in.
REQ-008 addr_in  in  32  effective address computed upstream.
REQ-009 wdata_in  in  32  store data.
REQ-010 stall_in  in  1  downstream (memory_wait stage) hold request.
REQ-011 mem_req  out  1  data-memory request.
REQ-012 mem_we  out  1  store (1) or load (0).
REQ-013 mem_addr  out  32  access address.
REQ-014 mem_wdata  out  32  store data lanes.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_ack  in  1  memory completion.
REQ-017 mem_rdata  in  32  load data, valid with mem_ack.
REQ-018 instr_output  out  32  registered instruction to the memory_wait stage.
REQ-019 branch_value  out  1  registered epoch tag accompanying instr_output.
REQ-020 load_data  out  32  registered, lane-aligned load result.
REQ-021 stall_out  out  1  hold request to the upstream stage.
REQ-022 mem_error  out  1  one-cycle pulse on timeout abort.

Function
REQ-023 A memory op is any instr_in with [27:26]=2'b01; L=instr_in[20] (load); B=instr_in[22] (byte).
REQ-024 A slot is squashed when branch_in != branch_ref: it issues no request and its instr_output is NOP_INSTR.
REQ-025 FSM states: IDLE, ACCESS, ABORT.
REQ-026 IDLE, stall_in=0, non-memory or squashed instr: instr_output, branch_value update at the next edge (1-cycle latency); load_data holds its value.
REQ-027 IDLE, stall_in=0, unsquashed memory op: go to ACCESS at the next edge; latch mem_we=~L, mem_addr, mem_wdata and mem_be; clear the timeout counter.
REQ-028 Word access: mem_addr[1:0]=2'b00 and mem_be=4'b1111.
REQ-029 Byte access: mem_addr=addr_in; mem_be=4'b0001<<addr_in[1:0]; mem_wdata=wdata_in[7:0] replicated on all four lanes.
REQ-030 ACCESS: mem_req=1 and all mem_* outputs stay constant until mem_ack=1.
REQ-031 On the ACCESS edge with mem_ack=1: go to IDLE; instr_output and branch_value take the latched slot.
REQ-032 On a load completing at that edge, load_data takes mem_rdata (word), or the addressed byte lane zero-extended (byte).
REQ-033 ACCESS with no mem_ack: the counter increments each cycle; when it reaches TIMEOUT_CYCLES, go to ABORT.
REQ-034 ABORT lasts one cycle: mem_error=1, mem_req=0, instr_output=NOP_INSTR; then return to IDLE.
REQ-035 stall_out=1 whenever the state is ACCESS or ABORT, or stall_in=1.
REQ-036 stall_in=1 in IDLE: all registered outputs hold and no new access starts.
REQ-037 stall_in=1 during ACCESS: does not stop the access; the completed result is presented and then held until stall_in falls.
REQ-038 A late mem_ack arriving in ABORT or IDLE is ignored.
REQ-039 mem_ack and the timeout limit in the same cycle: mem_ack wins and there is no error.

Reset
REQ-040 While rst_n=1, asynchronously: state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, instr_output=NOP_INSTR, branch_value=0, load_data=0, mem_error=0.
REQ-041 Reset during ACCESS drops mem_req immediately; the aborted access raises no mem_error.
REQ-042 stall_out is 0 during reset unless stall_in=1.

Verification
REQ-043 LDR word: addr 0x1003, ack after 3 cycles, rdata 0xDEADBEEF -> mem_addr=0x1000, be=1111, stall_out high 3 cycles, load_data=0xDEADBEEF.
REQ-044 STRB: addr 0x2002, wdata 0x000000A5 -> be=0100, mem_wdata=0xA5A5A5A5, mem_we=1; single-cycle ack -> IDLE next edge.
REQ-045 LDRB: addr 0x11, rdata 0x11223344 -> load_data=0x00000033.
REQ-046 Squash: memory op with branch_in != branch_ref -> mem_req never asserts; instr_output=0xE1A00000.
REQ-047 Timeout: TIMEOUT_CYCLES=4, ack held low -> mem_error pulses once after 4 ACCESS cycles; a later ack is ignored; ack arriving on the 4th cycle gives no error.
REQ-048 Reset asserted mid-ACCESS -> mem_req=0 at once, state=IDLE, and the outputs match REQ-040.
